instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Boot-time writer for the CPU's instruction memory. The CPU core only reads that memory.
- Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into one 32-bit instruction word. Writes words to consecutive word-aligned addresses starting at 0.
- Holds the CPU in reset while loading and releases it when the requested word count has been written.

Parameters:
- ADDR_WIDTH, 10, word-address width; memory depth = 2^ADDR_WIDTH words.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- start_i  input  1  begin a load; sampled only in IDLE or DONE.
- word_count_i  input  ADDR_WIDTH+1  number of words to load; sampled with start_i.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- mem_we_o  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr_o  output  32  byte address of the write = word index << 2.
- mem_data_o  output  32  assembled instruction word.
- cpu_rst_o  output  1  active-low reset to the CPU; 0 = CPU held.
- busy_o  output  1  load in progress (RECV or WRITE).
- done_o  output  1  high while in DONE.
- err_o  output  1  one-cycle pulse: start rejected.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State goes to IDLE; word index and byte counter go to 0; assembly register is cleared.
  - Outputs: byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_rst_o=0, busy_o=0, done_o=0, err_o=0.
  - Reset mid-load discards any partial word; no write is issued.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - cpu_rst_o=0; byte_ready_o=0.
  - start_i=1 with word_count_i > 2^ADDR_WIDTH: err_o=1 next cycle, stay IDLE.
  - start_i=1 with word_count_i=0: go to DONE.
  - start_i=1 otherwise: latch the count, clear index and byte counter, go to RECV.
- RECV:
  - byte_ready_o=1 combinationally.
  - A byte is accepted when byte_valid_i and byte_ready_o are both 1. Bytes with valid=0 are ignored, and idle gaps of any length are allowed.
  - Packing is little-endian: byte k of the word (k=0..3) goes to bits [8k+7:8k].
  - On accepting byte 3, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we_o=1, mem_addr_o={index,2'b00} zero-extended to 32 bits, mem_data_o=assembled word; byte_ready_o=0.
  - Latency: 4th byte accepted at edge N; mem_we_o is high during the cycle after edge N.
  - Next state: if index+1 == latched count, go to DONE. Otherwise increment index, clear the byte counter, go to RECV.
  - The index never wraps, because the count is bounded by the start check.
- DONE:
  - cpu_rst_o=1, done_o=1, byte_ready_o=0.
  - start_i=1 re-arms with the same checks as IDLE: cpu_rst_o drops to 0 on the next cycle and the load restarts at address 0.
- start_i is ignored in RECV and WRITE; no error is raised.
- mem_we_o is never asserted outside WRITE.
- mem_addr_o and mem_data_o hold their last written values outside WRITE.
- busy_o = (state==RECV || state==WRITE).
- All outputs except byte_ready_o are registered.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles, then release -> IDLE; cpu_rst_o=0; all other outputs 0.
- Start with word_count_i=2, stream bytes 0x13,0x00,0x10,0x20 then 0x44,0x33,0x22,0x11 with no gaps. Required response:
  - First write: mem_we_o pulse with addr 0x0, data 0x20100013.
  - Second write: addr 0x4, data 0x11223344.
  - Then done_o=1 and cpu_rst_o=1.
  - No third mem_we_o.
- Same load with byte_valid_i toggling 1/0 every cycle -> identical writes; each mem_we_o occurs the cycle after the 4th accepted byte.
- Start with word_count_i=0 -> DONE the next cycle with no writes. Start with word_count_i=2^ADDR_WIDTH+1 (1025) -> err_o pulses once, state stays IDLE, byte_ready_o stays 0.
- Assert rst_i=0 after 2 bytes of the first word -> no mem_we_o. A fresh start then writes its first word to addr 0x0 with only the new bytes.
- From DONE, start with word_count_i=1 -> cpu_rst_o goes to 0; one write to addr 0x0; DONE again. start_i pulsed during RECV has no effect.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot loader for the instruction memory: packs a little-endian byte stream into
// 32-bit words, writes them from address 0 upward and releases the CPU when done.
module instr_mem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   word_count_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  cpu_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [31:0]            asm_q, asm_d;
    logic                   mem_we_q, mem_we_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [31:0]            mem_data_q, mem_data_d;
    logic                   cpu_rst_q, cpu_rst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic can_start, count_bad, count_zero, arm_ok, accept, last_word;

    assign can_start  = start_i && (state_q == IDLE || state_q == DONE);
    assign count_bad  = word_count_i > MAX_WORDS;
    assign count_zero = word_count_i == '0;
    assign arm_ok     = can_start && !count_bad && !count_zero;
    assign accept     = byte_valid_i && (state_q == RECV);
    assign last_word  = ({1'b0, idx_q} + (ADDR_WIDTH+1)'(1)) == cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (can_start && !count_bad) begin
                    state_d = count_zero ? DONE : RECV;
                end
            end
            RECV:    if (accept && byte_cnt_q == 2'd3) state_d = WRITE;
            WRITE:   state_d = last_word ? DONE : RECV;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        byte_ready_o = (state_q == RECV);
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        if (arm_ok) begin
            cnt_d      = word_count_i;
            idx_d      = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
        end
        if (accept) begin
            asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data_i;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
        if (state_q == WRITE && !last_word) begin
            idx_d      = idx_q + ADDR_WIDTH'(1);
            byte_cnt_d = '0;
        end
        mem_we_d = (state_d == WRITE);
        if (mem_we_d) begin
            mem_addr_d = {{(30-ADDR_WIDTH){1'b0}}, idx_q, 2'b00};
            mem_data_d = asm_d;
        end
        cpu_rst_d = (state_d == DONE);
        done_d    = (state_d == DONE);
        busy_d    = (state_d == RECV) || (state_d == WRITE);
        err_d     = can_start && count_bad;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: expected writes are queued as bytes are
// driven and compared when mem_we_o appears; write latency is tracked per accepted byte.
module tb_instr_mem_loader;

    localparam int AW = 10;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW:0]   word_count_i;
    logic          byte_valid_i;
    logic [7:0]    byte_data_i;
    logic          byte_ready_o;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_data_o;
    logic          cpu_rst_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .word_count_i (word_count_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on every write, and write must follow the 4th accepted byte.
    int   mon_bytes = 0;
    logic we_due    = 1'b0;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            mon_bytes = 0;
            we_due    = 1'b0;
        end else begin
            if (we_due || mem_we_o) check_eq("we_latency", {31'd0, mem_we_o}, {31'd0, we_due});
            we_due = 1'b0;
            if (mem_we_o) begin
                $display("write addr=0x%08h data=0x%08h", mem_addr_o, mem_data_o);
                check_eq("sb_nonempty", {31'd0, exp_addr_q.size() != 0}, 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check_eq("wr_addr", mem_addr_o, exp_addr_q.pop_front());
                    check_eq("wr_data", mem_data_o, exp_data_q.pop_front());
                end
            end
            if (byte_valid_i && byte_ready_o) begin
                mon_bytes++;
                if (mon_bytes == 4) begin
                    mon_bytes = 0;
                    we_due    = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_load(input int count);
        start_i      = 1'b1;
        word_count_i = count[AW:0];
        tick();
        start_i      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int   guard;
        logic acc;
        if (gap) begin
            byte_valid_i = 1'b0;
            tick();
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        guard        = 0;
        acc          = 1'b0;
        do begin
            acc = byte_ready_o;
            tick();
            guard++;
        end while (!acc && guard < 50);
        check_eq("byte_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, input int idx, input bit expect_wr);
        if (expect_wr) begin
            exp_addr_q.push_back(idx * 4);
            exp_data_q.push_back(w);
        end
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done();
        int guard;
        byte_valid_i = 1'b0;
        guard        = 0;
        while (!done_o && guard < 200) begin
            tick();
            guard++;
        end
        check_eq("done_o", {31'd0, done_o}, 32'd1);
        check_eq("cpu_rst_o_done", {31'd0, cpu_rst_o}, 32'd1);
        check_eq("busy_o_done", {31'd0, busy_o}, 32'd0);
        repeat (4) tick();
        check_eq("sb_drained", exp_addr_q.size(), 32'd0);
    endtask

    initial begin
        rst_i        = 1'b0;
        start_i      = 1'b0;
        word_count_i = '0;
        byte_valid_i = 1'b0;
        byte_data_i  = '0;

        // Reset held for two cycles
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        check_eq("rst_ready",   {31'd0, byte_ready_o}, 32'd0);
        check_eq("rst_we",      {31'd0, mem_we_o},     32'd0);
        check_eq("rst_addr",    mem_addr_o,            32'd0);
        check_eq("rst_data",    mem_data_o,            32'd0);
        check_eq("rst_cpu_rst", {31'd0, cpu_rst_o},    32'd0);
        check_eq("rst_busy",    {31'd0, busy_o},       32'd0);
        check_eq("rst_done",    {31'd0, done_o},       32'd0);
        check_eq("rst_err",     {31'd0, err_o},        32'd0);

        // Oversized count rejected from IDLE
        start_load(1025);
        check_eq("err_pulse", {31'd0, err_o},        32'd1);
        check_eq("err_ready", {31'd0, byte_ready_o}, 32'd0);
        check_eq("err_busy",  {31'd0, busy_o},       32'd0);
        tick();
        check_eq("err_single",    {31'd0, err_o},        32'd0);
        check_eq("err_ready2",    {31'd0, byte_ready_o}, 32'd0);
        check_eq("err_stay_idle", {31'd0, done_o},       32'd0);

        // Zero count goes straight to DONE
        start_load(0);
        check_eq("zero_done",    {31'd0, done_o},    32'd1);
        check_eq("zero_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        repeat (3) tick();

        // Two words, back-to-back bytes, re-armed from DONE
        start_load(2);
        check_eq("arm_cpu_rst", {31'd0, cpu_rst_o},    32'd0);
        check_eq("arm_busy",    {31'd0, busy_o},       32'd1);
        check_eq("arm_ready",   {31'd0, byte_ready_o}, 32'd1);
        send_word(32'h2010_0013, 1'b0, 0, 1'b1);
        send_word(32'h1122_3344, 1'b0, 1, 1'b1);
        wait_done();
        check_eq("hold_addr", mem_addr_o, 32'h4);
        check_eq("hold_data", mem_data_o, 32'h1122_3344);

        // Same load with valid toggling every cycle
        start_load(2);
        send_word(32'h2010_0013, 1'b1, 0, 1'b1);
        send_word(32'h1122_3344, 1'b1, 1, 1'b1);
        wait_done();

        // Reset mid-word drops the partial word
        start_load(2);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        byte_valid_i = 1'b0;
        rst_i        = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        check_eq("abort_addr", mem_addr_o, 32'd0);
        check_eq("abort_data", mem_data_o, 32'd0);
        check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
        start_load(1);
        send_word(32'hDDCC_BBAA, 1'b0, 0, 1'b1);
        wait_done();

        // Re-arm from DONE with one word; start pulse mid-load is ignored
        start_load(1);
        check_eq("rearm_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
        exp_addr_q.push_back(32'd0);
        exp_data_q.push_back(32'h0BAD_F00D);
        send_byte(8'h0D, 1'b0);
        send_byte(8'hF0, 1'b0);
        byte_valid_i = 1'b0;
        start_load(3);
        check_eq("ign_start_busy", {31'd0, busy_o}, 32'd1);
        check_eq("ign_start_err",  {31'd0, err_o},  32'd0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'h0B, 1'b0);
        wait_done();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
